remap_cache_dm: RTL
===================

Name: remap_cache_dm

Overview:
- Parametrised direct-mapped read cache with selectable XOR set-index remapping and configurable width and depth.
- Accepts address requests on a rdy/ack input port and returns data on a rdy/ack output port.
- Misses are serviced through a separate miss-request / fill rdy/ack port pair; at most one miss is outstanding.
- Sits between an address generator and the memory-side fetch unit of the datapath.

Parameters:
- AW, 16, address width in bits.
- DW, 32, data width in bits.
- IDXW, 4, set-index width; the cache has 2**IDXW lines. Requires 2*IDXW <= AW.
- HASH, 1, set-index mode. 1 = index is addr[IDXW-1:0] XOR addr[2*IDXW-1:IDXW]. 0 = index is addr[IDXW-1:0].

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- ra_rdy  in  1  request valid.
- ra_ack  out  1  request accepted.
- i_ra_addr  in  AW  request address.
- rd_rdy  out  1  response valid.
- rd_ack  in  1  response taken.
- o_rd_data  out  DW  response data.
- o_rd_hit  out  1  response was a hit.
- mr_rdy  out  1  miss request valid.
- mr_ack  in  1  miss request taken.
- o_mr_addr  out  AW  miss address.
- mf_rdy  in  1  fill data valid.
- mf_ack  out  1  fill accepted.
- i_mf_data  in  DW  fill data.
- i_flush  in  1  invalidate all lines.

Behaviour:
- Transfer rule: a transfer occurs on a port in the cycle its rdy and ack are both 1. Once asserted, rdy holds its value and its payload stays stable until the transfer.
- Tag is addr[AW-1:IDXW], which keeps the XOR index invertible. Storage is flop arrays: valid[2**IDXW], tag[2**IDXW], data[2**IDXW].
- FSM states: IDLE, CHECK, MREQ, MWAIT, OUT. The next three bullets give the transitions.
- IDLE:
  - ra_ack = ra_rdy && !i_flush.
  - i_flush=1: clear all valid bits next cycle, stay in IDLE.
  - Otherwise, on a ra transfer: latch address, go to CHECK.
- CHECK:
  - Hit (valid[idx] && tag match): latch data[idx], set hit flag, go to OUT.
  - Miss: go to MREQ.
- MREQ:
  - mr_rdy=1, o_mr_addr = latched address.
  - On transfer, go to MWAIT.
- MWAIT:
  - mf_ack = mf_rdy, combinational.
  - On transfer: write data[idx], tag[idx], set valid[idx], latch fill data, clear hit flag, go to OUT.
- OUT:
  - rd_rdy=1 with o_rd_data and o_rd_hit.
  - On rd transfer, go to IDLE.
- Latency:
  - Hit: request transfer in cycle t, rd_rdy in t+2.
  - Miss: mr_rdy in t+2; rd_rdy the cycle after the fill transfer.
- Back-to-back: the next request is accepted no earlier than the cycle after the rd transfer.
- i_flush outside IDLE is ignored; it must be held until IDLE to take effect.
- A miss overwrites the line unconditionally; the evicted line is not written back (read-only cache).
- A fill to an index is visible to the next request.
- Reset (any state, including mid-miss):
  - State goes to IDLE and all valid bits clear.
  - ra_ack, rd_rdy, mr_rdy, mf_ack, o_rd_hit are all 0.
  - o_rd_data and o_mr_addr are 0.
  - An in-flight fill is dropped: mf_ack is 0 after reset, and the memory side must also be reset.

Optional Feature:
- REMAP_CACHE_STAT_EN defined:
  - Adds outputs o_hit_cnt[31:0] and o_miss_cnt[31:0], both 0 at reset.
  - Each counter increments by 1 in the CHECK cycle on hit or miss respectively, saturating at 32'hFFFFFFFF.
  - i_flush in IDLE clears both counters.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Cold miss. After reset, request addr 16'h0123 with HASH=1 (idx = 3^2 = 1):
  - mr_rdy with o_mr_addr=16'h0123.
  - Fill 32'hDEADBEEF, then rd_rdy with data 32'hDEADBEEF, o_rd_hit=0.
- Hit. Re-request 16'h0123:
  - No mr_rdy.
  - rd_rdy 2 cycles after the ra transfer, data 32'hDEADBEEF, o_rd_hit=1.
- Conflict. Request 16'h0132 (idx 2^3 = 1, same set, different tag):
  - Miss, fill 32'h11111111, then 16'h0123 misses again.
  - With HASH=0, 16'h0123 and 16'h0133 conflict instead (both idx 3).
- Backpressure:
  - Hold rd_ack=0 for 5 cycles: rd_rdy and data stay stable, ra_ack=0 throughout.
  - Hold mr_ack=0 for 3 cycles: mr_rdy and o_mr_addr stay stable.
- Flush. After filling 16'h0123, pulse i_flush in IDLE with ra_rdy=1:
  - ra_ack=0 in that cycle.
  - The following request to 16'h0123 misses; with the macro defined, both counters read 0 before that request.
- Reset mid-miss. Assert i_rst in MWAIT:
  - Next cycle all outputs are 0.
  - Re-request 16'h0123 misses.

Source files
------------

// File: rtl/remap_cache_dm.sv
// remap_cache_dm: direct-mapped read-only cache with optional XOR set-index
// remapping. One request is handled at a time; misses issue a single
// outstanding miss request and wait for the matching fill.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   ra_rdy/ra_ack, i_ra_addr      request address handshake
//   rd_rdy/rd_ack, o_rd_data,     response handshake, data and hit flag
//   o_rd_hit
//   mr_rdy/mr_ack, o_mr_addr      miss request handshake
//   mf_rdy/mf_ack, i_mf_data      fill handshake
//   i_flush                       invalidate all lines (honoured in IDLE)
//   o_hit_cnt, o_miss_cnt         saturating hit/miss counters, present only
//                                 when REMAP_CACHE_STAT_EN is defined
module remap_cache_dm #(
   parameter int unsigned AW   = 16,
   parameter int unsigned DW   = 32,
   parameter int unsigned IDXW = 4,
   parameter int unsigned HASH = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          ra_rdy,
   output logic          ra_ack,
   input  logic [AW-1:0] i_ra_addr,
   output logic          rd_rdy,
   input  logic          rd_ack,
   output logic [DW-1:0] o_rd_data,
   output logic          o_rd_hit,
   output logic          mr_rdy,
   input  logic          mr_ack,
   output logic [AW-1:0] o_mr_addr,
   input  logic          mf_rdy,
   output logic          mf_ack,
   input  logic [DW-1:0] i_mf_data,
   input  logic          i_flush
`ifdef REMAP_CACHE_STAT_EN
   ,
   output logic [31:0]   o_hit_cnt,
   output logic [31:0]   o_miss_cnt
`endif
);

   localparam int unsigned NLINES = 1 << IDXW;
   localparam int unsigned TW     = AW - IDXW;

   typedef enum logic [2:0] {IDLE, CHECK, MREQ, MWAIT, OUT} state_t;

   state_t               state_q, state_d;
   logic [AW-1:0]        addr_q;
   logic [DW-1:0]        data_q;
   logic                 hit_q;
   logic [NLINES-1:0]    valid_q;
   logic [TW-1:0]        tag_mem  [NLINES];
   logic [DW-1:0]        data_mem [NLINES];

   logic [IDXW-1:0]      idx;
   logic [TW-1:0]        tag_in;
   logic                 hit_c;
   logic                 fill_fire;

   // Set index from the latched address; the tag keeps all bits above the
   // low index field so the XOR mapping stays invertible.
   always_comb begin
      idx = addr_q[IDXW-1:0];
      if (HASH != 0) idx = addr_q[IDXW-1:0] ^ addr_q[2*IDXW-1:IDXW];
   end

   assign tag_in    = addr_q[AW-1:IDXW];
   assign hit_c     = valid_q[idx] && (tag_mem[idx] == tag_in);
   assign fill_fire = (state_q == MWAIT) && mf_rdy;

   assign rd_rdy    = (state_q == OUT);
   assign mr_rdy    = (state_q == MREQ);
   assign o_mr_addr = addr_q;
   assign o_rd_data = data_q;
   assign o_rd_hit  = hit_q;

   // Next-state and combinational handshake acks
   always_comb begin
      state_d = state_q;
      ra_ack  = 1'b0;
      mf_ack  = 1'b0;
      case (state_q)
         IDLE: begin
            ra_ack = ra_rdy && !i_flush;
            if (ra_rdy && !i_flush) state_d = CHECK;
         end
         CHECK:   state_d = hit_c ? OUT : MREQ;
         MREQ:    if (mr_ack) state_d = MWAIT;
         MWAIT: begin
            mf_ack = mf_rdy;
            if (mf_rdy) state_d = OUT;
         end
         OUT:     if (rd_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, valid bits and response registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         valid_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && i_flush) valid_q <= '0;
         if (ra_ack) addr_q <= i_ra_addr;
         if ((state_q == CHECK) && hit_c) begin
            data_q <= data_mem[idx];
            hit_q  <= 1'b1;
         end
         if (fill_fire) begin
            valid_q[idx] <= 1'b1;
            data_q       <= i_mf_data;
            hit_q        <= 1'b0;
         end
      end
   end

   // Tag/data storage; a fill coinciding with reset is dropped
   always_ff @(posedge i_clk) begin
      if (!i_rst && fill_fire) begin
         tag_mem[idx]  <= tag_in;
         data_mem[idx] <= i_mf_data;
      end
   end

`ifdef REMAP_CACHE_STAT_EN
   // Saturating hit/miss counters, cleared by reset or a flush in IDLE
   always_ff @(posedge i_clk) begin
      if (i_rst || ((state_q == IDLE) && i_flush)) begin
         o_hit_cnt  <= '0;
         o_miss_cnt <= '0;
      end else if (state_q == CHECK) begin
         if (hit_c && (o_hit_cnt != 32'hFFFF_FFFF))
            o_hit_cnt <= o_hit_cnt + 32'd1;
         if (!hit_c && (o_miss_cnt != 32'hFFFF_FFFF))
            o_miss_cnt <= o_miss_cnt + 32'd1;
      end
   end
`endif

endmodule
